serdes_rx_deframer: RTL and testbench

Receive-side frame parser that consumes the aligned 16-bit user word stream produced by the SerDes link interface (`O_user_data` / `O_data_ena`) in the `I_serdes_rx_clk` domain. It locates frames, validates length and checksum, and forwards payload words with start/end markers. It reports per-frame status and keeps saturating good and bad frame counters. It sits between the link interface and the application receive logic. It has no backpressure, because the link cannot be stalled.

---
 rtl/serdes_rx_deframer_pkg.sv | 10 +
 rtl/serdes_rx_deframer_if.sv | 27 ++
 rtl/serdes_rx_deframer_gap_timer.sv | 19 +
 rtl/serdes_rx_deframer.sv | 109 ++++++++++
 tb/tb_serdes_rx_deframer.sv | 132 +++++++++++++
 5 files changed

// File: rtl/serdes_rx_deframer_pkg.sv
// serdes_rx_pkg: shared state, error-cause and default definitions for the SerDes RX path.
package serdes_rx_pkg;
    typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CSUM} state_t;
    // Error-cause codes are shared with the TX framer; keep the encoding stable.
    typedef enum logic [1:0] {ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT} err_t;
    localparam logic [15:0] SOF_DEFAULT = 16'hA55A;
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/serdes_rx_deframer_if.sv
// serdes_rx_deframer_if: link-side word stream in, payload and frame status out.
interface serdes_rx_deframer_if;
    logic [15:0] I_user_data;
    logic        I_data_ena;
    logic        I_link_up;
    logic [15:0] O_pl_data;
    logic        O_pl_valid;
    logic        O_pl_sof;
    logic        O_pl_eof;
    logic        O_frame_done;
    logic        O_frame_ok;
    logic        O_err_len;
    logic        O_err_csum;
    logic        O_err_timeout;
    logic [15:0] O_frame_cnt;
    logic [15:0] O_err_cnt;
    modport master (
        output I_user_data, I_data_ena, I_link_up,
        input  O_pl_data, O_pl_valid, O_pl_sof, O_pl_eof, O_frame_done, O_frame_ok,
               O_err_len, O_err_csum, O_err_timeout, O_frame_cnt, O_err_cnt
    );
    modport slave (
        input  I_user_data, I_data_ena, I_link_up,
        output O_pl_data, O_pl_valid, O_pl_sof, O_pl_eof, O_frame_done, O_frame_ok,
               O_err_len, O_err_csum, O_err_timeout, O_frame_cnt, O_err_cnt
    );
endinterface

// File: rtl/serdes_rx_deframer_gap_timer.sv
// serdes_rx_gap_timer: counts consecutive idle cycles inside a frame; expire on the P_GAP_TIMEOUT-th.
module serdes_rx_gap_timer #(
    parameter int P_GAP_TIMEOUT = 64
) (
    input  logic I_serdes_rx_clk,
    input  logic I_rst_n,
    input  logic en,
    input  logic kick,
    output logic expire
);
    localparam int W = $clog2(P_GAP_TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(P_GAP_TIMEOUT - 1);
    logic [W-1:0] cnt;
    // A valid word on the would-be timeout cycle wins over the timeout.
    assign expire = en && !kick && cnt == LAST;
    always_ff @(posedge I_serdes_rx_clk or negedge I_rst_n)
        if (!I_rst_n) cnt <= '0;
        else cnt <= (!en || kick || expire) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/serdes_rx_deframer.sv
// serdes_rx_deframer: locates SOF/len/payload/checksum frames and forwards payload with status.
module serdes_rx_deframer
    import serdes_rx_pkg::*;
#(
    parameter logic [15:0] P_SOF         = SOF_DEFAULT,
    parameter int          P_MAX_LEN     = 256,
    parameter int          P_GAP_TIMEOUT = 64
) (
    input logic I_serdes_rx_clk,
    input logic I_rst_n,
    serdes_rx_deframer_if.slave bus
);
    localparam logic [16:0] MAX_LEN = 17'(P_MAX_LEN);
    state_t      state, state_n;
    logic [15:0] acc, acc_n, rem, rem_n, len, len_n, pl_data_n;
    logic        pl_valid_n, pl_sof_n, pl_eof_n, done_n, expire;
    err_t        err_n;
    wire  [15:0] d = bus.I_user_data;
    serdes_rx_gap_timer #(.P_GAP_TIMEOUT(P_GAP_TIMEOUT)) u_gap (
        .I_serdes_rx_clk(I_serdes_rx_clk),
        .I_rst_n        (I_rst_n),
        .en             (state != IDLE && bus.I_link_up),
        .kick           (bus.I_data_ena),
        .expire         (expire)
    );
    always_comb begin
        state_n    = state;
        acc_n      = acc;
        rem_n      = rem;
        len_n      = len;
        pl_data_n  = bus.O_pl_data;
        pl_valid_n = 1'b0;
        pl_sof_n   = 1'b0;
        pl_eof_n   = 1'b0;
        done_n     = 1'b0;
        err_n      = ERR_NONE;
        if (!bus.I_link_up) begin
            state_n = IDLE;
        end else if (bus.I_data_ena) begin
            case (state)
                IDLE: state_n = (d == P_SOF) ? LEN : IDLE;
                LEN: begin
                    len_n = d;
                    acc_n = d;
                    rem_n = d;
                    if (d == 16'd0 || {1'b0, d} > MAX_LEN) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        err_n   = ERR_LEN;
                    end else begin
                        state_n = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    pl_data_n  = d;
                    pl_valid_n = 1'b1;
                    pl_sof_n   = rem == len;
                    pl_eof_n   = rem == 16'd1;
                    acc_n      = acc + d;
                    rem_n      = rem - 16'd1;
                    state_n    = (rem == 16'd1) ? CSUM : PAYLOAD;
                end
                CSUM: begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    err_n   = (d == acc) ? ERR_NONE : ERR_CSUM;
                end
            endcase
        end else if (expire) begin
            state_n = IDLE;
            done_n  = 1'b1;
            err_n   = ERR_TIMEOUT;
        end
    end
    always_ff @(posedge I_serdes_rx_clk or negedge I_rst_n)
        if (!I_rst_n) begin
            state             <= IDLE;
            acc               <= '0;
            rem               <= '0;
            len               <= '0;
            bus.O_pl_data     <= '0;
            bus.O_pl_valid    <= 1'b0;
            bus.O_pl_sof      <= 1'b0;
            bus.O_pl_eof      <= 1'b0;
            bus.O_frame_done  <= 1'b0;
            bus.O_frame_ok    <= 1'b0;
            bus.O_err_len     <= 1'b0;
            bus.O_err_csum    <= 1'b0;
            bus.O_err_timeout <= 1'b0;
            bus.O_frame_cnt   <= '0;
            bus.O_err_cnt     <= '0;
        end else begin
            state             <= state_n;
            acc               <= acc_n;
            rem               <= rem_n;
            len               <= len_n;
            bus.O_pl_data     <= pl_data_n;
            bus.O_pl_valid    <= pl_valid_n;
            bus.O_pl_sof      <= pl_sof_n;
            bus.O_pl_eof      <= pl_eof_n;
            bus.O_frame_done  <= done_n;
            bus.O_frame_ok    <= done_n && err_n == ERR_NONE;
            bus.O_err_len     <= done_n && err_n == ERR_LEN;
            bus.O_err_csum    <= done_n && err_n == ERR_CSUM;
            bus.O_err_timeout <= done_n && err_n == ERR_TIMEOUT;
            bus.O_frame_cnt   <= (done_n && err_n == ERR_NONE) ? sat_inc(bus.O_frame_cnt) : bus.O_frame_cnt;
            bus.O_err_cnt     <= (done_n && err_n != ERR_NONE) ? sat_inc(bus.O_err_cnt) : bus.O_err_cnt;
        end
endmodule

// File: tb/tb_serdes_rx_deframer.sv
// tb_serdes_rx_deframer: directed vector table plus hand sequences for gaps, link drop and reset.
module tb_serdes_rx_deframer;
    typedef struct {
        logic        en;
        logic [15:0] d;
        logic [7:0]  f;
        logic [15:0] pd;
        logic [15:0] fc;
        logic [15:0] ec;
    } vec_t;
    localparam logic [7:0] FV = 8'h80, FS = 8'h40, FE = 8'h20, FD = 8'h10,
                           FOK = 8'h08, FL = 8'h04, FC = 8'h02, FT = 8'h01;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0, bad = 0;
    vec_t tbl [27];
    serdes_rx_deframer_if bus();
    serdes_rx_deframer dut (.I_serdes_rx_clk(clk), .I_rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    function automatic vec_t v(input logic en, input logic [15:0] d, input logic [7:0] f,
                               input logic [15:0] pd, input logic [15:0] fc, input logic [15:0] ec);
        vec_t r;
        r.en = en; r.d = d; r.f = f; r.pd = pd; r.fc = fc; r.ec = ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] f, input logic [15:0] pd,
                       input logic [15:0] fc, input logic [15:0] ec);
        logic [7:0] g;
        g = {bus.O_pl_valid, bus.O_pl_sof, bus.O_pl_eof, bus.O_frame_done, bus.O_frame_ok,
             bus.O_err_len, bus.O_err_csum, bus.O_err_timeout};
        total++;
        if (g !== f || bus.O_frame_cnt !== fc || bus.O_err_cnt !== ec || (f[7] && bus.O_pl_data !== pd)) begin
            bad++;
            $display("FAIL %s: flags=%b data=%h fcnt=%0d ecnt=%0d, want flags=%b data=%h fcnt=%0d ecnt=%0d",
                     name, g, bus.O_pl_data, bus.O_frame_cnt, bus.O_err_cnt, f, pd, fc, ec);
        end
    endtask

    task automatic step(input logic en, input logic [15:0] d, input logic [7:0] f, input logic [15:0] pd,
                        input logic [15:0] fc, input logic [15:0] ec, input string name);
        bus.I_data_ena  = en;
        bus.I_user_data = d;
        @(posedge clk);
        #1;
        chk(name, f, pd, fc, ec);
    endtask

    task automatic good3(input logic [15:0] fc, input logic [15:0] ec, input string name);
        step(1, 16'hA55A, 0, 0, fc, ec, name);
        step(1, 16'h0003, 0, 0, fc, ec, name);
        step(1, 16'h1111, FV | FS, 16'h1111, fc, ec, name);
        step(1, 16'h2222, FV, 16'h2222, fc, ec, name);
        step(1, 16'h3333, FV | FE, 16'h3333, fc, ec, name);
        step(1, 16'h6669, FD | FOK, 0, fc + 16'd1, ec, name);
    endtask

    initial begin
        tbl = '{
            v(0, 16'h0000, 0, 0, 0, 0),          v(1, 16'h1234, 0, 0, 0, 0),
            v(1, 16'hA55A, 0, 0, 0, 0),          v(1, 16'h0003, 0, 0, 0, 0),
            v(1, 16'h1111, FV | FS, 16'h1111, 0, 0),
            v(1, 16'h2222, FV, 16'h2222, 0, 0),  v(0, 16'h0000, 0, 0, 0, 0),
            v(1, 16'h3333, FV | FE, 16'h3333, 0, 0),
            v(1, 16'h6669, FD | FOK, 0, 1, 0),
            v(1, 16'hA55A, 0, 0, 1, 0),          v(1, 16'h0003, 0, 0, 1, 0),
            v(1, 16'h1111, FV | FS, 16'h1111, 1, 0),
            v(1, 16'h2222, FV, 16'h2222, 1, 0),
            v(1, 16'h3333, FV | FE, 16'h3333, 1, 0),
            v(1, 16'h0000, FD | FC, 0, 1, 1),
            v(1, 16'hA55A, 0, 0, 1, 1),          v(1, 16'h0000, FD | FL, 0, 1, 2),
            v(1, 16'hA55A, 0, 0, 1, 2),          v(1, 16'h0101, FD | FL, 0, 1, 3),
            v(1, 16'hA55A, 0, 0, 1, 3),          v(1, 16'h0001, 0, 0, 1, 3),
            v(1, 16'hFFFF, FV | FS | FE, 16'hFFFF, 1, 3),
            v(1, 16'h0000, FD | FOK, 0, 2, 3),
            v(1, 16'hA55A, 0, 0, 2, 3),          v(1, 16'h0001, 0, 0, 2, 3),
            v(1, 16'h0005, FV | FS | FE, 16'h0005, 2, 3),
            v(1, 16'h0006, FD | FOK, 0, 3, 3)
        };
        bus.I_user_data = 16'h0;
        bus.I_data_ena  = 1'b0;
        bus.I_link_up   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 27; i++)
            step(tbl[i].en, tbl[i].d, tbl[i].f, tbl[i].pd, tbl[i].fc, tbl[i].ec, $sformatf("vec%0d", i));

        step(1, 16'hA55A, 0, 0, 3, 3, "gap_a");
        step(1, 16'h0004, 0, 0, 3, 3, "gap_a");
        step(1, 16'h0001, FV | FS, 16'h0001, 3, 3, "gap_a");
        step(1, 16'h0002, FV, 16'h0002, 3, 3, "gap_a");
        for (int i = 1; i <= 64; i++)
            step(0, 16'h0, (i == 64) ? (FD | FT) : 8'h0, 0, 3, (i == 64) ? 16'd4 : 16'd3, "gap_a_idle");

        step(1, 16'hA55A, 0, 0, 3, 4, "gap_b");
        step(1, 16'h0004, 0, 0, 3, 4, "gap_b");
        step(1, 16'h0001, FV | FS, 16'h0001, 3, 4, "gap_b");
        step(1, 16'h0002, FV, 16'h0002, 3, 4, "gap_b");
        for (int i = 1; i <= 63; i++) step(0, 16'h0, 0, 0, 3, 4, "gap_b_idle");
        step(1, 16'h0003, FV, 16'h0003, 3, 4, "gap_b");
        step(1, 16'h0004, FV | FE, 16'h0004, 3, 4, "gap_b");
        step(1, 16'h000E, FD | FOK, 0, 4, 4, "gap_b_csum");

        step(1, 16'hA55A, 0, 0, 4, 4, "link");
        step(1, 16'h0100, 0, 0, 4, 4, "link_len256");
        step(1, 16'h1111, FV | FS, 16'h1111, 4, 4, "link");
        bus.I_link_up = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 16'h2222, 0, 0, 4, 4, "link_down");
        step(0, 16'h0, 0, 0, 4, 4, "link_down");
        bus.I_link_up = 1'b1;
        step(1, 16'h2222, 0, 0, 4, 4, "link_up_word");
        good3(4, 4, "link_good");

        step(1, 16'hA55A, 0, 0, 5, 4, "rst");
        step(1, 16'h0003, 0, 0, 5, 4, "rst");
        step(1, 16'h1111, FV | FS, 16'h1111, 5, 4, "rst");
        rst_n = 1'b0;
        #2;
        chk("rst_mid", 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1, 16'h2222, 0, 0, 0, 0, "rst_after");
        good3(0, 0, "rst_good");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
